// File: rtl/mem_stage_pkg.sv
// Shared constants and FSM state encoding for the memory-access stage.
package mem_stage_pkg;

    localparam int WORD_DEF     = 32;
    localparam int REG_ADDR_DEF = 4;
    localparam int ADDR_W_DEF   = 6;
    localparam int MEM_BASE_DEF = 1024;
    localparam int TIMEOUT_DEF  = 15;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_BUSY = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a frozen cycle loads a bubble so write-back never repeats.
module mem_wb_reg
    import mem_stage_pkg::*;
#(
    parameter int WORD     = WORD_DEF,
    parameter int REG_ADDR = REG_ADDR_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                wb_en_in,
    input  logic                mem_read_in,
    input  logic [WORD-1:0]     alu_result_in,
    input  logic [WORD-1:0]     mem_data_in,
    input  logic [REG_ADDR-1:0] dest_in,
    output logic                wb_en_out,
    output logic                mem_read_out,
    output logic [WORD-1:0]     alu_result_out,
    output logic [WORD-1:0]     mem_data_out,
    output logic [REG_ADDR-1:0] dest_out
);

    logic                wb_en_q, wb_en_d;
    logic                mem_read_q, mem_read_d;
    logic [WORD-1:0]     alu_result_q, alu_result_d;
    logic [WORD-1:0]     mem_data_q, mem_data_d;
    logic [REG_ADDR-1:0] dest_q, dest_d;

    always_comb begin
        wb_en_d      = 1'b0;
        mem_read_d   = 1'b0;
        alu_result_d = alu_result_q;
        mem_data_d   = mem_data_q;
        dest_d       = dest_q;
        if (!freeze) begin
            wb_en_d      = wb_en_in;
            mem_read_d   = mem_read_in;
            alu_result_d = alu_result_in;
            mem_data_d   = mem_data_in;
            dest_d       = dest_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_q      <= 1'b0;
            mem_read_q   <= 1'b0;
            alu_result_q <= '0;
            mem_data_q   <= '0;
            dest_q       <= '0;
        end else begin
            wb_en_q      <= wb_en_d;
            mem_read_q   <= mem_read_d;
            alu_result_q <= alu_result_d;
            mem_data_q   <= mem_data_d;
            dest_q       <= dest_d;
        end
    end

    assign wb_en_out      = wb_en_q;
    assign mem_read_out   = mem_read_q;
    assign alu_result_out = alu_result_q;
    assign mem_data_out   = mem_data_q;
    assign dest_out       = dest_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: req/ack sequencing to variable-latency data memory, stall and timeout.
// state    | meaning
// MEM_IDLE | no access in flight; a load/store command freezes upstream and launches a request
// MEM_BUSY | request held high awaiting mem_ack, bounded by TIMEOUT cycles
// MEM_DONE | access finished; freeze released so MEM/WB captures the command with the buffer
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WORD     = WORD_DEF,
    parameter int REG_ADDR = REG_ADDR_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int MEM_BASE = MEM_BASE_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_en_in,
    input  logic                mem_read_in,
    input  logic                mem_write_in,
    input  logic [WORD-1:0]     alu_result_in,
    input  logic [WORD-1:0]     val_Rm_in,
    input  logic [REG_ADDR-1:0] dest_in,
    input  logic                mem_ack,
    input  logic [WORD-1:0]     mem_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [WORD-1:0]     mem_wdata,
    output logic                freeze,
    output logic                err,
    output logic                wb_en_out,
    output logic                mem_read_out,
    output logic [WORD-1:0]     alu_result_out,
    output logic [WORD-1:0]     mem_data_out,
    output logic [REG_ADDR-1:0] dest_out
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD-1:0]   rbuf_q, rbuf_d;
    logic [WORD-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              freeze_c;
    logic              mem_cmd;

    assign mem_cmd = mem_read_in | mem_write_in;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rbuf_d   = rbuf_q;
        wdata_d  = wdata_q;
        addr_d   = addr_q;
        req_d    = req_q;
        we_d     = we_q;
        err_d    = 1'b0;
        freeze_c = 1'b0;
        unique case (state_q)
            MEM_IDLE: begin
                if (mem_cmd) begin
                    freeze_c = 1'b1;
                    req_d    = 1'b1;
                    we_d     = mem_write_in;
                    // Word address relative to MEM_BASE; byte offset dropped, high bits wrap.
                    addr_d   = ADDR_W'((alu_result_in - WORD'(MEM_BASE)) >> 2);
                    wdata_d  = val_Rm_in;
                    cnt_d    = '0;
                    state_d  = MEM_BUSY;
                end
            end
            MEM_BUSY: begin
                freeze_c = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (mem_ack) begin
                    rbuf_d  = mem_rdata;
                    req_d   = 1'b0;
                    state_d = MEM_DONE;
                end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                    rbuf_d  = '0;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = MEM_DONE;
                end
            end
            MEM_DONE: state_d = MEM_IDLE;
            default:  state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
            rbuf_q  <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rbuf_q  <= rbuf_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err       = err_q;
    assign freeze    = freeze_c;

    mem_wb_reg #(
        .WORD     (WORD),
        .REG_ADDR (REG_ADDR)
    ) u_mem_wb_reg (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze_c),
        .wb_en_in       (wb_en_in),
        .mem_read_in    (mem_read_in),
        .alu_result_in  (alu_result_in),
        .mem_data_in    (rbuf_q),
        .dest_in        (dest_in),
        .wb_en_out      (wb_en_out),
        .mem_read_out   (mem_read_out),
        .alu_result_out (alu_result_out),
        .mem_data_out   (mem_data_out),
        .dest_out       (dest_out)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage against a transaction-level model of the access protocol.
module tb_mem_stage;

    localparam int WORD     = 32;
    localparam int REG_ADDR = 4;
    localparam int ADDR_W   = 6;
    localparam int MEM_BASE = 1024;
    localparam int TIMEOUT  = 15;

    logic                clk = 1'b0;
    logic                rst;
    logic                wb_en_in, mem_read_in, mem_write_in;
    logic [WORD-1:0]     alu_result_in, val_Rm_in;
    logic [REG_ADDR-1:0] dest_in;
    logic                mem_ack;
    logic [WORD-1:0]     mem_rdata;
    logic                mem_req, mem_we, freeze, err;
    logic [ADDR_W-1:0]   mem_addr;
    logic [WORD-1:0]     mem_wdata;
    logic                wb_en_out, mem_read_out;
    logic [WORD-1:0]     alu_result_out, mem_data_out;
    logic [REG_ADDR-1:0] dest_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: read buffer and the last MEM/WB alu/dest actually loaded.
    logic [WORD-1:0]     mdl_buf;
    logic [WORD-1:0]     mdl_alu;
    logic [REG_ADDR-1:0] mdl_dest;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .wb_en_in       (wb_en_in),
        .mem_read_in    (mem_read_in),
        .mem_write_in   (mem_write_in),
        .alu_result_in  (alu_result_in),
        .val_Rm_in      (val_Rm_in),
        .dest_in        (dest_in),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .freeze         (freeze),
        .err            (err),
        .wb_en_out      (wb_en_out),
        .mem_read_out   (mem_read_out),
        .alu_result_out (alu_result_out),
        .mem_data_out   (mem_data_out),
        .dest_out       (dest_out)
    );

    function automatic logic [ADDR_W-1:0] exp_addr(input logic [WORD-1:0] a);
        longint off;
        off = a;
        off = off - MEM_BASE;
        if (off < 0) off = off + (longint'(1) << WORD);
        return ADDR_W'((off / 4) % (longint'(1) << ADDR_W));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_inputs();
        wb_en_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        alu_result_in = '0; val_Rm_in = '0; dest_in = '0;
        mem_ack = 1'b0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_idle_inputs();
        #2;
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, err, freeze, wb_en_out, mem_read_out,
             alu_result_out, mem_data_out, dest_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h err=%b frz=%b wb=%b rd=%b alu=%h data=%h dest=%h, all required 0",
                     mem_req, mem_we, mem_addr, mem_wdata, err, freeze, wb_en_out, mem_read_out,
                     alu_result_out, mem_data_out, dest_out);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        mdl_buf = '0; mdl_alu = '0; mdl_dest = '0;
    endtask

    // Non-memory instruction, optionally with a spurious ack while IDLE.
    task automatic test_alu_op(input int count);
        for (int i = 0; i < count; i++) begin
            logic                wb;
            logic [WORD-1:0]     alu;
            logic [REG_ADDR-1:0] dst;
            wb  = 1'($urandom_range(0, 1));
            alu = (i == 0) ? 32'h2A : $urandom;
            dst = (i == 0) ? 4'd3 : REG_ADDR'($urandom);
            if (i == 0) wb = 1'b1;
            wb_en_in = wb; mem_read_in = 1'b0; mem_write_in = 1'b0;
            alu_result_in = alu; dest_in = dst; val_Rm_in = $urandom;
            mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
            @(negedge clk);
            n_checks++;
            if ({freeze, mem_req} !== 2'b00) begin
                n_fail++;
                $display("FAIL alu_freeze: freeze=%b req=%b, required 0 0", freeze, mem_req);
            end
            tick();
            mem_ack = 1'b0;
            n_checks++;
            if ({wb_en_out, mem_read_out, alu_result_out, dest_out, mem_data_out, err} !==
                {wb, 1'b0, alu, dst, mdl_buf, 1'b0}) begin
                n_fail++;
                $display("FAIL alu_memwb: wb=%b rd=%b alu=%h dest=%h data=%h err=%b, required wb=%b rd=0 alu=%h dest=%h data=%h err=0",
                         wb_en_out, mem_read_out, alu_result_out, dest_out, mem_data_out, err,
                         wb, alu, dst, mdl_buf);
            end
            mdl_alu = alu; mdl_dest = dst;
        end
    endtask

    // One load or store; ack_cycle is the BUSY cycle carrying mem_ack (0 = never).
    // Leaves the DUT in the IDLE cycle after DONE with the command still on the inputs,
    // so the caller must present the next instruction immediately.
    task automatic run_mem(input logic rd, input logic wr, input logic wb,
                           input logic [WORD-1:0] alu, input logic [WORD-1:0] wdata,
                           input logic [REG_ADDR-1:0] dst, input int ack_cycle,
                           input logic [WORD-1:0] rdata);
        logic [ADDR_W-1:0] ea;
        logic              acked;
        int                frz_cycles;
        int                busy_cycles;
        ea = exp_addr(alu);
        acked = 1'b0;
        frz_cycles = 0;
        busy_cycles = 0;
        wb_en_in = wb; mem_read_in = rd; mem_write_in = wr;
        alu_result_in = alu; val_Rm_in = wdata; dest_in = dst;
        mem_ack = 1'b0; mem_rdata = $urandom;
        @(negedge clk);
        if (freeze === 1'b1) frz_cycles++;
        n_checks++;
        if ({mem_req, freeze} !== 2'b01) begin
            n_fail++;
            $display("FAIL cmd_idle: req=%b freeze=%b, required req=0 freeze=1", mem_req, freeze);
        end
        for (int n = 1; n <= TIMEOUT; n++) begin
            tick();
            busy_cycles = n;
            if (n == ack_cycle) begin mem_ack = 1'b1; mem_rdata = rdata; end
            else begin mem_ack = 1'b0; mem_rdata = $urandom; end
            @(negedge clk);
            if (freeze === 1'b1) frz_cycles++;
            n_checks++;
            if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, wr, ea, wdata}) begin
                n_fail++;
                $display("FAIL busy_bus cyc %0d: req=%b we=%b addr=%0d wdata=%h, required req=1 we=%b addr=%0d wdata=%h",
                         n, mem_req, mem_we, mem_addr, mem_wdata, wr, ea, wdata);
            end
            n_checks++;
            if ({wb_en_out, mem_read_out, alu_result_out, dest_out, err} !==
                {2'b00, mdl_alu, mdl_dest, 1'b0}) begin
                n_fail++;
                $display("FAIL busy_bubble cyc %0d: wb=%b rd=%b alu=%h dest=%h err=%b, required wb=0 rd=0 alu=%h dest=%h err=0",
                         n, wb_en_out, mem_read_out, alu_result_out, dest_out, err, mdl_alu, mdl_dest);
            end
            if (n == ack_cycle) begin acked = 1'b1; break; end
        end
        tick();
        mem_ack = 1'b0;
        mdl_buf = acked ? rdata : '0;
        @(negedge clk);
        n_checks++;
        if ({freeze, mem_req, err} !== {2'b00, ~acked}) begin
            n_fail++;
            $display("FAIL done_state: freeze=%b req=%b err=%b, required freeze=0 req=0 err=%b",
                     freeze, mem_req, err, ~acked);
        end
        n_checks++;
        if (frz_cycles != 1 + busy_cycles) begin
            n_fail++;
            $display("FAIL freeze_len: %0d frozen cycles, required %0d", frz_cycles, 1 + busy_cycles);
        end
        tick();
        n_checks++;
        if ({wb_en_out, mem_read_out, alu_result_out, dest_out, mem_data_out, err} !==
            {wb, rd, alu, dst, mdl_buf, 1'b0}) begin
            n_fail++;
            $display("FAIL mem_memwb: wb=%b rd=%b alu=%h dest=%h data=%h err=%b, required wb=%b rd=%b alu=%h dest=%h data=%h err=0",
                     wb_en_out, mem_read_out, alu_result_out, dest_out, mem_data_out, err,
                     wb, rd, alu, dst, mdl_buf);
        end
        mdl_alu = alu; mdl_dest = dst;
    endtask

    task automatic test_ldr();
        run_mem(1'b1, 1'b0, 1'b1, 32'd1032, $urandom, 4'd5, 2, 32'hDEADBEEF);
        test_alu_op(1);
    endtask

    task automatic test_str();
        run_mem(1'b0, 1'b1, 1'b0, 32'd1024, 32'h12345678, 4'd7, 1, $urandom);
        test_alu_op(1);
    endtask

    task automatic test_back_to_back();
        run_mem(1'b1, 1'b0, 1'b1, $urandom, $urandom, REG_ADDR'($urandom), 3, $urandom);
        run_mem(1'b0, 1'b1, 1'b0, $urandom, $urandom, REG_ADDR'($urandom), 1, $urandom);
        test_alu_op(3);
    endtask

    task automatic test_timeout();
        run_mem(1'b1, 1'b0, 1'b1, $urandom, $urandom, REG_ADDR'($urandom), 0, $urandom);
        test_alu_op(2);
        // Ack on the last allowed BUSY cycle must beat the timeout.
        run_mem(1'b1, 1'b0, 1'b1, $urandom, $urandom, REG_ADDR'($urandom), TIMEOUT, $urandom);
        test_alu_op(1);
    endtask

    task automatic test_reset_mid_busy();
        wb_en_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0;
        alu_result_in = $urandom; val_Rm_in = $urandom; dest_in = 4'd9;
        mem_ack = 1'b0;
        tick();
        #2;
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_req: req=%b, required 1", mem_req);
        end
        set_idle_inputs();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, err, freeze, wb_en_out, mem_read_out,
             alu_result_out, mem_data_out, dest_out} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: req=%b frz=%b wb=%b alu=%h data=%h dest=%h, all required 0",
                     mem_req, freeze, wb_en_out, alu_result_out, mem_data_out, dest_out);
        end
        mem_ack = 1'b1; mem_rdata = $urandom;
        @(negedge clk);
        rst = 1'b1;
        tick();
        mdl_buf = '0; mdl_alu = '0; mdl_dest = '0;
        n_checks++;
        if ({mem_req, freeze, wb_en_out, mem_data_out} !== '0) begin
            n_fail++;
            $display("FAIL rst_late_ack: req=%b frz=%b wb=%b data=%h, required all 0",
                     mem_req, freeze, wb_en_out, mem_data_out);
        end
        mem_ack = 1'b0;
        test_alu_op(1);
    endtask

    task automatic test_random(input int count);
        for (int i = 0; i < count; i++) begin
            logic rd;
            logic wb;
            rd = 1'($urandom_range(0, 1));
            wb = rd & 1'($urandom_range(0, 1));
            run_mem(rd, ~rd, wb, $urandom, $urandom, REG_ADDR'($urandom),
                    $urandom_range(0, TIMEOUT), $urandom);
            if ($urandom_range(0, 1) == 1) test_alu_op(1);
        end
        test_alu_op(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_op(4);
        test_ldr();
        test_str();
        test_back_to_back();
        test_timeout();
        test_reset_mid_busy();
        test_random(12);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage ARM pipeline. Consumes the EXE/MEM register contents: the ALU result as the address, and val_Rm as the store data.
- Runs a req/ack handshake to a variable-latency data memory and raises freeze to stall the upstream stages while an access is in flight.
- Owns the MEM/WB pipeline register that feeds write-back.

Parameters:
- WORD, 32, datapath width.
- REG_ADDR, 4, destination register index width.
- ADDR_W, 6, data-memory word-address width.
- MEM_BASE, 1024, byte address mapped to memory word 0.
- TIMEOUT, 15, max BUSY cycles before the access is abandoned.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- wb_en_in  in  1  write-back enable from EXE/MEM.
- mem_read_in  in  1  load command.
- mem_write_in  in  1  store command.
- alu_result_in  in  WORD  ALU result / byte address.
- val_Rm_in  in  WORD  store data.
- dest_in  in  REG_ADDR  destination register.
- mem_ack  in  1  memory completion strobe.
- mem_rdata  in  WORD  read data, valid with mem_ack.
- mem_req  out  1  access request, registered.
- mem_we  out  1  1 = write, registered.
- mem_addr  out  ADDR_W  word address, registered.
- mem_wdata  out  WORD  write data, registered.
- freeze  out  1  stall for IF/ID/EXE and their pipeline registers.
- err  out  1  one-cycle pulse on timeout.
- wb_en_out  out  1  MEM/WB register output.
- mem_read_out  out  1  MEM/WB register output.
- alu_result_out  out  WORD  MEM/WB register output.
- mem_data_out  out  WORD  MEM/WB register output.
- dest_out  out  REG_ADDR  MEM/WB register output.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE; timeout counter = 0; read buffer = 0.
  - mem_req, mem_we, mem_addr, mem_wdata, err = 0.
  - All MEM/WB outputs = 0.
  - freeze = 0, since it is decoded from state and inputs.
  - Reset mid-access drops mem_req immediately; any late mem_ack is ignored.
- Address: mem_addr = bits [ADDR_W+1:2] of (alu_result_in - MEM_BASE). Subtraction is modulo 2^WORD; byte offset bits are ignored; out-of-range addresses wrap.
- State IDLE:
  - If mem_read_in|mem_write_in: freeze=1 this cycle. Next edge registers mem_req=1, mem_we=mem_write_in, mem_addr, mem_wdata=val_Rm_in, clears the counter, and goes to BUSY.
  - Otherwise: freeze=0 (pass-through, zero added latency).
- State BUSY:
  - freeze=1; mem_req held high; address and data stable.
  - Counter increments each cycle.
  - On mem_ack=1: capture mem_rdata into the read buffer, drop mem_req, go to DONE.
  - If the counter reaches TIMEOUT without ack: drop mem_req, buffer=0, err=1 for one cycle, go to DONE.
  - Ack and timeout in the same cycle: ack wins, err stays 0.
- State DONE:
  - freeze=0. The MEM/WB register captures the command with mem_data_out = buffer.
  - Next state is IDLE unconditionally. Upstream advances on the same edge, so a back-to-back access starts in the following IDLE cycle.
- mem_ack is sampled only in BUSY; ack in IDLE or DONE is ignored.
- Memory-op latency: minimum 3 cycles from command presented to MEM/WB update (IDLE, BUSY, DONE) with an ack on the first BUSY cycle.
- MEM/WB register updates every edge:
  - freeze=0: load wb_en, mem_read, alu_result, dest from the inputs; mem_data_out = buffer.
  - freeze=1: load a bubble (wb_en_out=0, mem_read_out=0; other fields hold) so the register file is never written twice.
- Stores: wb_en_in is passed through as given; the decoder guarantees wb_en_in=0 for STR.

Decomposition:
- Shared defines (existing defines file): WORD, REG_ADDR width, MEM_BASE, state encodings MEM_IDLE/MEM_BUSY/MEM_DONE.
- One natural sub-module, mem_wb_reg: the MEM/WB register with its bubble-on-freeze input. The FSM, counter and address generation stay in mem_stage.

Test Plan:
- Reset mid-BUSY → mem_req and all outputs 0 asynchronously; a later mem_ack is ignored; state returns to IDLE.
- Non-memory ADD: wb_en_in=1, alu_result_in=0x2A, dest_in=3 → freeze=0; next edge wb_en_out=1, alu_result_out=0x2A, dest_out=3.
- LDR: alu_result_in=1032, memory acks 2 cycles after mem_req with rdata 0xDEADBEEF → mem_addr=2, mem_we=0; freeze high for 3 cycles; then mem_read_out=1, mem_data_out=0xDEADBEEF, wb_en_out=1 exactly once.
- STR: alu_result_in=1024, val_Rm_in=0x12345678, ack on the first BUSY cycle → mem_addr=0, mem_we=1, mem_wdata=0x12345678 stable while req; wb_en_out=0 throughout.
- Back-to-back LDR then STR, plus a spurious ack while IDLE → two distinct requests with the second mem_req rising one cycle after DONE; the spurious ack has no effect.
- mem_ack never arrives → err pulses after TIMEOUT=15 BUSY cycles; mem_data_out=0; freeze released; pipeline resumes.
